// File: rtl/fifo_reader.sv
// Adapts a shift_out/empty FIFO with one-cycle read latency to a valid/ready stream via a 2-entry skid buffer.
// Optional feature: define FIFO_READER_COUNT_EN to add the 16-bit word_count output.
module fifo_reader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             fifo_empty,
  output logic             fifo_shift_out,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef FIFO_READER_COUNT_EN
  ,
  output logic [15:0]      word_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic             inflight_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] head_reg, tail_reg;
  logic             pop, capture;
  logic [1:0]       occ;
  logic [2:0]       occ_after;

  assign capture = inflight_reg;
  assign pop     = out_valid_reg & out_ready;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_reg     <= EMPTY;
      inflight_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      inflight_reg  <= fifo_shift_out;
      out_valid_reg <= (state_next != EMPTY);
    end
  end

  always_comb begin
    state_next     = state_reg;
    occ            = 2'd0;
    occ_after      = 3'd0;
    fifo_shift_out = 1'b0;
    case (state_reg)
      EMPTY: occ = 2'd0;
      HALF:  occ = 2'd1;
      FULL:  occ = 2'd2;
      default: occ = 2'd0;
    endcase
    // Only strobe when the word it fetches is guaranteed a free slot on arrival.
    occ_after      = {1'b0, occ} + {2'b00, inflight_reg} - {2'b00, pop};
    fifo_shift_out = !res && !fifo_empty && (occ_after <= 3'd1);
    case (state_reg)
      EMPTY: if (capture) state_next = HALF;
      HALF: begin
        if (capture && !pop)      state_next = FULL;
        else if (pop && !capture) state_next = EMPTY;
      end
      FULL: if (pop && !capture) state_next = HALF;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else if (state_reg == FULL) begin
      if (pop) begin
        head_reg <= tail_reg;
        if (capture) tail_reg <= fifo_rdata;
      end
    end else if (capture) begin
      // With one or zero words left after this cycle, the new word becomes the head.
      if (state_reg == EMPTY || pop) head_reg <= fifo_rdata;
      else                           tail_reg <= fifo_rdata;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = head_reg;

`ifdef FIFO_READER_COUNT_EN
  logic [15:0] count_reg;

  always_ff @(posedge clk or posedge res) begin
    if (res)      count_reg <= 16'h0000;
    else if (pop) count_reg <= count_reg + 16'h0001;
  end

  assign word_count = count_reg;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: queue-based upstream FIFO, scoreboard of expected words.
// Define FIFO_READER_COUNT_EN to also exercise the word_count wrap test.
module tb_fifo_reader;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         res = 1'b1;
  logic         fifo_empty = 1'b1;
  logic         fifo_shift_out;
  logic [W-1:0] fifo_rdata = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
`ifdef FIFO_READER_COUNT_EN
  logic [15:0]  word_count;
`endif

  fifo_reader #(.WIDTH(W)) dut (
    .clk(clk),
    .res(res),
    .fifo_empty(fifo_empty),
    .fifo_shift_out(fifo_shift_out),
    .fifo_rdata(fifo_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef FIFO_READER_COUNT_EN
    ,
    .word_count(word_count)
`endif
  );

  always #5 clk = ~clk;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fetched = 0;
  int accepted = 0;
  int strobe_cnt = 0;
  int first_strobe = -1;
  int first_valid = -1;
  int last_pop_cyc = -1;
  bit hold_pend = 0;
  bit quiet = 0;
  logic [W-1:0] hold_data = '0;

  task automatic push_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_stats();
    fetched = 0; accepted = 0; strobe_cnt = 0;
    first_strobe = -1; first_valid = -1; last_pop_cyc = -1;
    hold_pend = 0; cyc = 0;
  endtask

  // One clock cycle; entered and left at a falling edge with out_ready already set.
  task automatic step();
    logic sv, ss;
    logic [W-1:0] sd, e;
    #1;
    sv = out_valid; sd = out_data; ss = fifo_shift_out;
    total++;
    if (fetched - accepted > 2) begin
      bad++; $display("FAIL overflow cyc=%0d outstanding=%0d required<=2", cyc, fetched - accepted);
    end
    total++;
    if (ss && fifo_empty) begin
      bad++; $display("FAIL strobe_on_empty cyc=%0d shift_out=%b required=0", cyc, ss);
    end
    if (hold_pend) begin
      total++;
      if (sv !== 1'b1 || sd !== hold_data) begin
        bad++; $display("FAIL hold cyc=%0d valid=%b data=%02h required valid=1 data=%02h", cyc, sv, sd, hold_data);
      end
    end
    hold_pend = sv && !out_ready;
    hold_data = sd;
    if (ss) begin
      strobe_cnt++;
      if (first_strobe < 0) first_strobe = cyc;
    end
    if (sv === 1'b1 && first_valid < 0) first_valid = cyc;
    if (sv === 1'b1 && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL extra_word cyc=%0d data=%02h required none", cyc, sd);
      end else begin
        e = exp_q.pop_front();
        if (sd !== e) begin
          bad++; $display("FAIL pop_data cyc=%0d data=%02h required=%02h", cyc, sd, e);
        end else if (!quiet) begin
          $display("pop cyc=%0d data=%02h", cyc, sd);
        end
      end
      accepted++;
      last_pop_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (ss === 1'b1 && fifo_q.size() > 0) begin
      fetched++;
      fifo_rdata = fifo_q.pop_front();
    end
    fifo_empty = (fifo_q.size() == 0);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    res = 1'b1;
    out_ready = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    repeat (2) @(negedge clk);
    res = 1'b0;
    clear_stats();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain_timeout remaining=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    fifo_q.push_back(8'h5A);
    fifo_empty = 1'b0;
    #2;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || fifo_shift_out !== 1'b0) begin
      bad++; $display("FAIL reset_state valid=%b data=%02h shift=%b required 0/00/0", out_valid, out_data, fifo_shift_out);
    end
    do_reset();
  endtask

  task automatic test_idle();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      total++;
      if (fifo_shift_out !== 1'b0 || out_valid !== 1'b0) begin
        bad++; $display("FAIL idle cyc=%0d shift=%b valid=%b required 0/0", i, fifo_shift_out, out_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stream();
    do_reset();
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    out_ready = 1'b1;
    drain(20);
    total++;
    if (first_valid - first_strobe != 2) begin
      bad++; $display("FAIL first_latency got=%0d required=2", first_valid - first_strobe);
    end
    total++;
    if (accepted != 3 || last_pop_cyc - first_valid != 2) begin
      bad++; $display("FAIL back_to_back pops=%0d span=%0d required 3/2", accepted, last_pop_cyc - first_valid);
    end
  endtask

  task automatic test_stall();
    do_reset();
    push_word(8'hC1); push_word(8'hC2); push_word(8'hC3); push_word(8'hC4);
    out_ready = 1'b0;
    repeat (8) step();
    #1;
    total++;
    if (strobe_cnt != 2) begin
      bad++; $display("FAIL stall_strobes got=%0d required=2", strobe_cnt);
    end
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hC1 || fifo_shift_out !== 1'b0) begin
      bad++; $display("FAIL stall_full valid=%b data=%02h shift=%b required 1/c1/0", out_valid, out_data, fifo_shift_out);
    end
    @(negedge clk);
    out_ready = 1'b1;
    drain(30);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 100; i++) push_word(W'($urandom_range(0, 255)));
    for (int n = 0; n < 1000 && exp_q.size() > 0; n++) begin
      out_ready = $urandom_range(0, 1) == 1;
      step();
    end
    out_ready = 1'b1;
    drain(20);
    total++;
    if (accepted != 100) begin
      bad++; $display("FAIL random_count got=%0d required=100", accepted);
    end
  endtask

  task automatic test_reset_full();
    do_reset();
    push_word(8'h71); push_word(8'h72); push_word(8'h73); push_word(8'h74);
    out_ready = 1'b0;
    repeat (6) step();
    res = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || fifo_shift_out !== 1'b0) begin
      bad++; $display("FAIL midreset valid=%b data=%02h shift=%b required 0/00/0", out_valid, out_data, fifo_shift_out);
    end
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    repeat (2) @(negedge clk);
    res = 1'b0;
    clear_stats();
    push_word(8'hA5);
    out_ready = 1'b1;
    repeat (8) step();
    total++;
    if (accepted != 1 || exp_q.size() != 0) begin
      bad++; $display("FAIL post_reset pops=%0d left=%0d required 1/0", accepted, exp_q.size());
    end
  endtask

`ifdef FIFO_READER_COUNT_EN
  task automatic test_count();
    int n = 0;
    do_reset();
    quiet = 1;
    out_ready = 1'b1;
    while (accepted < 65537 && n < 70000) begin
      while (fifo_q.size() < 4) push_word(W'($urandom_range(0, 255)));
      step();
      n++;
    end
    out_ready = 1'b0;
    quiet = 0;
    #1;
    total++;
    if (accepted != 65537 || word_count !== 16'd1) begin
      bad++; $display("FAIL word_count pops=%0d count=%0d required 65537/1", accepted, word_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_stream();
    test_stall();
    test_random();
    test_reset_full();
`ifdef FIFO_READER_COUNT_EN
    test_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
